// File: rtl/config_loader_pkg.sv
// Shared constants, state encoding and sizing helpers for the configuration-chain loader.
package config_loader_pkg;

    localparam int unsigned DEF_CONFIG_WIDTH = 707;
    localparam int unsigned DEF_WORD_WIDTH   = 32;
    localparam int unsigned DEF_CLK_DIV      = 2;
    localparam int unsigned DEF_SETTLE       = 5;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned num_words_f(input int unsigned cw, input int unsigned ww);
        return (cw + ww - 1) / ww;
    endfunction

    function automatic int unsigned last_bits_f(input int unsigned cw, input int unsigned ww);
        return cw - (num_words_f(cw, ww) - 1) * ww;
    endfunction

    function automatic int unsigned bit_cnt_w_f(input int unsigned cw);
        return $clog2(cw + 1);
    endfunction

    function automatic int unsigned idx_w_f(input int unsigned ww);
        return $clog2(ww);
    endfunction

    function automatic int unsigned phase_w_f(input int unsigned div, input int unsigned settle);
        return $clog2(max_u(div, settle) + 1);
    endfunction

    localparam int unsigned NUM_WORDS = num_words_f(DEF_CONFIG_WIDTH, DEF_WORD_WIDTH);
    localparam int unsigned LAST_BITS = last_bits_f(DEF_CONFIG_WIDTH, DEF_WORD_WIDTH);

endpackage

// File: rtl/cfg_word_serializer.sv
// Holds the current bitstream word and walks it LSB-first; flags the last bit of the word.
module cfg_word_serializer
    import config_loader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned IDX_W      = idx_w_f(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  advance,
    output logic                  next_bit_c,
    output logic                  last_c
);

    logic [WORD_WIDTH-1:0] sreg_q, sreg_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    always_comb begin
        sreg_d = sreg_q;
        idx_d  = idx_q;
        if (load) begin
            sreg_d = word_in;
            idx_d  = '0;
        end else if (advance) begin
            sreg_d = sreg_q >> 1;
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            idx_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            idx_q  <= idx_d;
        end
    end

    // Bit 0 is already on the chain input, so the bit that follows it is bit 1.
    assign next_bit_c = sreg_q[1];
    assign last_c     = (idx_q == IDX_W'(WORD_WIDTH - 1));

endmodule

// File: rtl/config_loader.sv
// Loads a host bitstream into the fabric serial configuration chain, LSB-first, with a divided shift clock.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int unsigned CONFIG_WIDTH = DEF_CONFIG_WIDTH,
    parameter int unsigned WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
    parameter int unsigned SETTLE       = DEF_SETTLE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_in,
    output logic                  config_clk,
    output logic                  config_en,
    input  logic                  config_out,
    output logic                  busy,
    output logic                  done,
    output logic                  tail_parity
);

    localparam int unsigned BIT_CNT_W = bit_cnt_w_f(CONFIG_WIDTH);
    localparam int unsigned IDX_W     = idx_w_f(WORD_WIDTH);
    localparam int unsigned CNT_W     = phase_w_f(CLK_DIV, SETTLE);

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d, bit_cnt_inc_c;
    logic                 config_in_q, config_in_d;
    logic                 config_clk_q, config_clk_d;
    logic                 config_en_q, config_en_d;
    logic                 word_ready_q, word_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tail_parity_q, tail_parity_d;
    logic                 ser_load_c, ser_advance_c, ser_next_bit_c, ser_last_c;

    assign bit_cnt_inc_c = bit_cnt_q + BIT_CNT_W'(1);

    cfg_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH),
        .IDX_W      (IDX_W)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load_c),
        .word_in    (word_data),
        .advance    (ser_advance_c),
        .next_bit_c (ser_next_bit_c),
        .last_c     (ser_last_c)
    );

    // Next state plus next value of every registered output.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        config_in_d   = config_in_q;
        config_clk_d  = 1'b0;
        config_en_d   = config_en_q;
        word_ready_d  = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        tail_parity_d = tail_parity_q;
        ser_load_c    = 1'b0;
        ser_advance_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_FETCH;
                    bit_cnt_d     = '0;
                    tail_parity_d = 1'b0;
                    busy_d        = 1'b1;
                    config_en_d   = 1'b1;
                    word_ready_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                config_en_d  = 1'b1;
                word_ready_d = 1'b1;
                if (word_valid && word_ready_q) begin
                    ser_load_c   = 1'b1;
                    config_in_d  = word_data[0];
                    cnt_d        = '0;
                    word_ready_d = 1'b0;
                    state_d      = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d         = '0;
                    config_clk_d  = 1'b1;
                    tail_parity_d = tail_parity_q ^ config_out;
                    state_d       = ST_SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_inc_c;
                    if (bit_cnt_inc_c == BIT_CNT_W'(CONFIG_WIDTH)) begin
                        config_en_d = 1'b0;
                        state_d     = ST_FINISH;
                    end else if (ser_last_c) begin
                        word_ready_d = 1'b1;
                        state_d      = ST_FETCH;
                    end else begin
                        ser_advance_c = 1'b1;
                        config_in_d   = ser_next_bit_c;
                        state_d       = ST_SHIFT_LO;
                    end
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    config_clk_d = 1'b1;
                end
            end
            ST_FINISH: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                busy_d      = 1'b0;
                config_en_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a word accepted in the same cycle.
        if (abort && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            config_en_d   = 1'b0;
            config_clk_d  = 1'b0;
            word_ready_d  = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            ser_load_c    = 1'b0;
            ser_advance_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            config_in_q   <= 1'b0;
            config_clk_q  <= 1'b0;
            config_en_q   <= 1'b0;
            word_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tail_parity_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            config_in_q   <= config_in_d;
            config_clk_q  <= config_clk_d;
            config_en_q   <= config_en_d;
            word_ready_q  <= word_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tail_parity_q <= tail_parity_d;
        end
    end

    assign config_in   = config_in_q;
    assign config_clk  = config_clk_q;
    assign config_en   = config_en_q;
    assign word_ready  = word_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tail_parity = tail_parity_q;

endmodule

// File: doc/config_loader.md
# config_loader

Sequencer that loads a bitstream into the fabric's serial configuration chain. It takes `WORD_WIDTH`-bit bitstream words from a host over a valid/ready handshake and drives `config_in`, `config_clk` and `config_en` into the top-level fabric. Bits go out LSB-first: bitstream bit 0 is shifted first. It stops after exactly `CONFIG_WIDTH` bits and then signals completion. It replaces the behavioural shift task used in simulation with synthesizable RTL, so the fabric can be configured on silicon.

## Interface
- `CONFIG_WIDTH`, 707: total configuration bits in the chain.
- `WORD_WIDTH`, 32: bitstream word width from the host.
- `CLK_DIV`, 2: `clk` cycles per `config_clk` phase, low and high alike; must be ≥1.
- `SETTLE`, 5: `clk` cycles that `config_en` stays low before `done` is raised.
- `clk` input, 1 bit: system clock; the only clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: a one-cycle pulse that begins a load; ignored while `busy`.
- `abort` input, 1 bit: cancels a load in progress.
- `word_data` input, `WORD_WIDTH` bits: bitstream word.
- `word_valid` input, 1 bit: `word_data` is valid.
- `word_ready` output, 1 bit: loader can accept a word.
- `config_in` output, 1 bit: serial data into the fabric chain.
- `config_clk` output, 1 bit: chain shift clock, generated from `clk`.
- `config_en` output, 1 bit: chain shift enable.
- `config_out` input, 1 bit: chain tail; XOR-folded into `tail_parity`.
- `busy` output, 1 bit: a load is in progress.
- `done` output, 1 bit: one-cycle pulse when a load completes normally.
- `tail_parity` output, 1 bit: XOR of `config_out` sampled at each rising edge of `config_clk` during the current or last load.

## Operation
- Reset values:
  - `config_in`, `config_clk`, `config_en`, `word_ready`, `busy`, `done` and `tail_parity` are all 0.
  - The bit counter is 0 and the FSM is in IDLE.
- FSM states: IDLE, FETCH, SHIFT_LO, SHIFT_HI, FINISH.
- IDLE:
  - On `start`, go to FETCH.
  - Clear the bit counter and `tail_parity`, and set `busy`.
- FETCH:
  - `config_en`=1, `word_ready`=1, `config_clk`=0.
  - On `word_valid`&&`word_ready`, latch `word_data` into the shift register, clear the in-word index and go to SHIFT_LO.
  - `config_clk` holds low indefinitely while the host underflows.
- SHIFT_LO:
  - `config_in` = current word bit; `config_clk`=0.
  - After `CLK_DIV` cycles, go to SHIFT_HI.
- SHIFT_HI:
  - `config_clk`=1 and `config_in` is held; `config_out` is sampled into `tail_parity` on entry.
  - After `CLK_DIV` cycles, the bit counter increments and one of three transitions follows:
    - If the counter reaches `CONFIG_WIDTH`, go to FINISH.
    - Otherwise, if the word is exhausted, go to FETCH.
    - Otherwise, go to SHIFT_LO with the next bit.
- Final word: only `CONFIG_WIDTH mod WORD_WIDTH` bits are shifted (3 with the defaults); the remaining upper bits are discarded. The loader accepts exactly ceil(`CONFIG_WIDTH`/`WORD_WIDTH`) words per load (23 with the defaults).
- FINISH:
  - `config_en`=0, `config_clk`=0 and `word_ready`=0.
  - Wait `SETTLE` cycles, then pulse `done` for one cycle, clear `busy` and return to IDLE.
- Abort:
  - `abort` in any non-IDLE state goes to IDLE on the next cycle.
  - `config_en`, `config_clk` and `word_ready` drop to 0 and `done` is not pulsed.
  - The chain contents are undefined after an abort.
- Simultaneous events:
  - `abort` has priority over a handshake in the same cycle; the word is consumed but discarded.
  - `start` together with `abort` in IDLE: `start` wins.
  - `start` while `busy` is ignored.
- Reset mid-load: all outputs return to their reset values asynchronously.

## Timing
- `start` at cycle 0 puts the FSM in FETCH at cycle 1, with `word_ready`=1 and `config_en`=1.
- The word handshake at cycle n puts the first bit on `config_in` at cycle n+1, and the `config_clk` rising edge at cycle n+1+`CLK_DIV`.
- `config_in` is stable for `CLK_DIV` cycles before each rising edge of `config_clk` and for `CLK_DIV` cycles after it.
- Per-bit period is 2·`CLK_DIV` cycles; each word adds a FETCH cycle of at least 1 cycle.
- Back-to-back load with defaults and a host that is always valid: 23 + 707·4 + `SETTLE` cycles from the first FETCH to the cycle before `done`, i.e. 2856 cycles.
- All outputs are registered.

## Structure
- Package `config_loader_pkg` holds:
  - the state enum;
  - `NUM_WORDS` = ceil(`CONFIG_WIDTH`/`WORD_WIDTH`);
  - `LAST_BITS` = `CONFIG_WIDTH`−(`NUM_WORDS`−1)·`WORD_WIDTH`;
  - the counter widths: $clog2(`CONFIG_WIDTH`+1), $clog2(`WORD_WIDTH`) and $clog2(max(`CLK_DIV`,`SETTLE`)+1).
- Sub-module `cfg_word_serializer` covers the word shift register plus the in-word index, and reports word-exhausted to the FSM.
- Top level contains the FSM, phase/settle counter, bit counter and parity.

## Test plan
- Full load, defaults, `word_valid` always 1, 23 words from a 707-bit file:
  - `config_in` sampled at each `config_clk` rise equals bitstream[0..706] in order;
  - exactly 707 rising edges; `done` after 2856+1 cycles.
- Host stall: drop `word_valid` for 10 cycles before word 5. `config_clk` stays 0 and `config_en` stays 1 for the stall, and the bit order is unchanged.
- Last word 32'hFFFF_FFF8: only bits 0–2 (0,0,0) are shifted; 707 edges in total; upper bits never appear.
- Abort after 100 bits: next cycle `config_en`=`config_clk`=`word_ready`=0, no `done`, `busy`=0. A new `start` then completes a full load correctly.
- `rst_n` low mid-SHIFT_HI: all outputs reset asynchronously without waiting for a `clk` edge.
- `start` during a load: ignored, edge count unchanged. With a fabric model whose chain is 707 bits preloaded with all ones, `tail_parity` equals 707 mod 2, i.e. 1.
